rv_tx_buffer: RTL and testbench
===============================

# rv_tx_buffer

Transmit-side endpoint of the valid/ready link. Buffers 64-bit result words produced by the systolic MAC array in a small FIFO, presents them downstream as `valid` + `data_out`, and holds each word stable until the receiver asserts `ready`. It is the source that drives the receiver's `valid`/`data_in` pins, and it consumes the receiver's `ready`.

## Interface
Parameters:
- `DATA_W`, 64: width of one transferred word.
- `DEPTH`, 4: FIFO entries. Must be a power of two and at least 2.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  producer push request.
- `wr_data`  in  DATA_W  word to push.
- `full`  out  1  combinational: `count == DEPTH`.
- `overflow`  out  1  sticky error: a push was attempted while full.
- `valid`  out  1  combinational: `count != 0`. This is the link valid.
- `ready`  in  1  link ready from the receiver.
- `data_out`  out  DATA_W  head-of-FIFO word: `mem[rd_ptr]`.
- `en_data_Tx`  out  1  combinational handshake strobe: `valid & ready`.
- `count`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- **Storage:** `mem[DEPTH]`, with `wr_ptr` and `rd_ptr` each $clog2(DEPTH) bits wide. Pointers wrap naturally modulo DEPTH.
- **Push:** `push = wr_en & ~full`.
  - On a push: `mem[wr_ptr] <= wr_data` and `wr_ptr <= wr_ptr + 1`.
- **Pop:** `pop = valid & ready`, identical to `en_data_Tx`.
  - On a pop: `rd_ptr <= rd_ptr + 1`.
- **Count update:**
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when push and pop occur together, or when neither occurs.
- **Full, `wr_en` asserted:** the word is dropped and `overflow <= 1`. This holds even if a pop occurs in the same cycle, because `full` is sampled before the edge. No state other than `overflow` changes due to the dropped write.
- **Empty, `ready` asserted:** no pop occurs. `en_data_Tx` is 0. `ready` may be high while `valid` is low.
- **Simultaneous push and pop when `count == 1`:** the head word is transferred, the new word becomes the head next cycle, and `valid` stays 1.
- **Handshake rules as source:**
  - Once `valid` rises, it stays high and `data_out` stays bit-stable until the cycle in which `ready` is high.
  - `valid` never depends combinationally on `ready`.
- **`overflow`:** cleared only by `reset`.
- **Reset:** `reset` high at any edge forces `wr_ptr = rd_ptr = count = 0` and `overflow = 0`.
  - In-flight FIFO contents are discarded.
  - `mem` is not cleared.
  - While `reset` is high, push and pop are ignored.

## Timing
- **Reset values:** `valid` = 0, `full` = 0, `overflow` = 0, `count` = 0, `en_data_Tx` = 0.
  - `data_out` is `mem[0]`, which is undefined until the first write.
- **Push-to-valid latency:** 1 cycle. A word pushed at edge N gives `valid` = 1 and `data_out = wr_data` after edge N.
- **Throughput:** one word per cycle when `ready` is held high and `wr_en` keeps the FIFO non-empty.
- **Transfer point:** the word is consumed at the edge where `en_data_Tx` = 1. The next word, or `valid` = 0, is visible after that edge.
- **Combinational paths:** `en_data_Tx` is combinational from `ready`. No other output depends combinationally on any input.

## Test plan
- **Reset then single transfer:**
  - Stimulus: after reset, push `64'hDEADBEEFCAFEBABE` with `ready` = 0.
  - Response: `valid` = 1 the next cycle, `data_out` holds that value for 3 cycles.
  - Then raise `ready`: `en_data_Tx` = 1 for exactly one cycle, after which `valid` = 0 and `count` = 0.
- **Fill, overflow and ordering:**
  - Stimulus: push 1, 2, 3, 4 with `ready` = 0.
  - Response: `full` = 1 and `count` = 4.
  - Push 5: `overflow` = 1 and `count` stays 4.
  - Drain with `ready` = 1: outputs are 1, 2, 3, 4 on consecutive cycles. 5 is never seen.
- **Streaming:**
  - Stimulus: `ready` = 1 constantly; push 0x10 through 0x17 on consecutive cycles.
  - Response: `en_data_Tx` is high for 8 consecutive cycles delivering 0x10 through 0x17 in order, and `count` never exceeds 1.
- **Wrap-around:**
  - Stimulus: repeat 3 pushes followed by 3 pops, five times, with values incrementing from 0xA0.
  - Response: all 15 values are received in order and `overflow` stays 0.
- **Simultaneous push/pop at boundaries:**
  - With `count` = 1 (head 0x1), push 0x2 while `ready` = 1. Response: 0x1 is transferred, `count` stays 1, and `data_out` = 0x2 next cycle.
  - With `count` = 4, push while `ready` = 1. Response: the push is dropped, `overflow` = 1, and `count` becomes 3.
- **Reset mid-operation:**
  - Stimulus: with `count` = 3 and `overflow` = 1, assert `reset` for 1 cycle while `wr_en` = 1 and `ready` = 1.
  - Response: `count` = 0, `valid` = 0, `overflow` = 0 afterward. The subsequent push of 0x55 appears as the first output.

Source files
------------

// File: rtl/rv_tx_buffer.sv
// rv_tx_buffer
//   Transmit-side endpoint of the valid/ready link. Result words from the MAC
//   array are pushed into a small circular FIFO. The head word is presented
//   downstream until the receiver accepts it.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high; clears pointers, count and overflow
//   wr_en       producer push request (ignored while full)
//   wr_data     word to push
//   full        count == DEPTH
//   overflow    sticky: a push was attempted while full
//   valid       link valid, count != 0
//   ready       link ready from the receiver
//   data_out    head-of-FIFO word
//   en_data_Tx  transfer strobe, valid & ready
//   count       current occupancy
//
// Handshake: a word transfers at a rising edge where valid and ready are both
// high. Once valid is raised it stays high, and data_out stays stable, until
// that edge. valid is derived only from registered state and never from ready.
// en_data_Tx is the only output with a combinational path from an input.
module rv_tx_buffer #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       full,
  output logic                       overflow,
  output logic                       valid,
  input  logic                       ready,
  output logic [DATA_W-1:0]          data_out,
  output logic                       en_data_Tx,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  assign full       = (count == CW'(DEPTH));
  assign valid      = (count != '0);
  assign data_out   = mem[rd_ptr];
  assign en_data_Tx = valid & ready;

  // full is taken from the pre-edge count, so a write is dropped while full
  // even when a pop frees a slot at the same edge.
  assign push = wr_en & ~full;
  assign pop  = en_data_Tx;

  // Storage has no reset; stale contents are unreachable once the pointers
  // and count are cleared.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv_tx_buffer.sv
module tb_rv_tx_buffer;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH+1);

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              overflow;
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data_out;
  logic              en_data_Tx;
  logic [CW-1:0]     count;

  rv_tx_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .overflow   (overflow),
    .valid      (valid),
    .ready      (ready),
    .data_out   (data_out),
    .en_data_Tx (en_data_Tx),
    .count      (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // exp_q holds the words the buffer should contain, head first.
  logic [DATA_W-1:0] exp_q[$];
  logic              exp_ovf;
  // rx_q collects words actually handed over on the link.
  logic [DATA_W-1:0] rx_q[$];

  int n_checks;
  int n_pass;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model across the rising edge.
  task automatic step(input logic we, input logic [DATA_W-1:0] wd,
                      input logic rd, input logic rs);
    logic exp_valid;
    logic exp_full;
    @(negedge clk);
    wr_en   = we;
    wr_data = wd;
    ready   = rd;
    reset   = rs;
    #1;
    exp_valid = (exp_q.size() != 0);
    exp_full  = (exp_q.size() == DEPTH);
    chk("valid",      DATA_W'(valid),      DATA_W'(exp_valid));
    chk("full",       DATA_W'(full),       DATA_W'(exp_full));
    chk("count",      DATA_W'(count),      DATA_W'(exp_q.size()));
    chk("overflow",   DATA_W'(overflow),   DATA_W'(exp_ovf));
    chk("en_data_Tx", DATA_W'(en_data_Tx), DATA_W'(exp_valid & rd));
    if (exp_valid) begin
      chk("data_out", data_out, exp_q[0]);
    end
    if (valid && ready && !rs) begin
      rx_q.push_back(data_out);
    end
    @(posedge clk);
    if (rs) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      if (exp_valid && rd) void'(exp_q.pop_front());
      if (we && exp_full) exp_ovf = 1'b1;
      if (we && !exp_full) exp_q.push_back(wd);
    end
  endtask

  // Compare the received stream against an arithmetic run first..first+n-1.
  task automatic check_rx(input string tag, input logic [DATA_W-1:0] first,
                          input int n);
    chk({tag, "_len"}, DATA_W'(rx_q.size()), DATA_W'(n));
    for (int i = 0; i < n; i++) begin
      if (rx_q.size() != 0) begin
        chk({tag, "_word"}, rx_q.pop_front(), first + DATA_W'(i));
      end
    end
    rx_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_ovf  = 1'b0;
    reset    = 1'b1;
    wr_en    = 1'b0;
    wr_data  = '0;
    ready    = 1'b0;

    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    rx_q.delete();

    // Reset then single transfer, held for 3 cycles before ready.
    step(1'b1, 64'hDEADBEEFCAFEBABE, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("single_len", DATA_W'(rx_q.size()), 64'd1);
    if (rx_q.size() != 0) chk("single_word", rx_q.pop_front(), 64'hDEADBEEFCAFEBABE);
    rx_q.delete();

    // Fill, overflow and ordering.
    for (int i = 1; i <= 4; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0);
    step(1'b1, 64'd5, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    repeat (5) step(1'b0, '0, 1'b1, 1'b0);
    check_rx("fill", 64'd1, 4);

    step(1'b0, '0, 1'b0, 1'b1);

    // Streaming with ready held high.
    for (int i = 0; i < 8; i++) step(1'b1, 64'h10 + DATA_W'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check_rx("stream", 64'h10, 8);

    // Wrap-around: 3 pushes then 3 pops, five times.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) step(1'b1, 64'hA0 + DATA_W'(r*3 + i), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    end
    chk("wrap_ovf", DATA_W'(overflow), 64'd0);
    check_rx("wrap", 64'hA0, 15);

    // Simultaneous push/pop with one entry.
    step(1'b1, 64'h1, 1'b0, 1'b0);
    step(1'b1, 64'h2, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("pp1_count", DATA_W'(count), 64'd1);
    chk("pp1_head",  data_out, 64'h2);
    step(1'b0, '0, 1'b1, 1'b0);
    check_rx("pp1", 64'h1, 2);

    // Simultaneous push/pop while full: write dropped, count drops to 3.
    for (int i = 0; i < 4; i++) step(1'b1, 64'h30 + DATA_W'(i), 1'b0, 1'b0);
    step(1'b1, 64'h99, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("ppf_count", DATA_W'(count), 64'd3);
    chk("ppf_ovf",   DATA_W'(overflow), 64'd1);

    // Reset mid-operation with wr_en and ready high.
    step(1'b1, 64'h77, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rst_count", DATA_W'(count), 64'd0);
    chk("rst_valid", DATA_W'(valid), 64'd0);
    chk("rst_ovf",   DATA_W'(overflow), 64'd0);
    rx_q.delete();
    step(1'b1, 64'h55, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check_rx("rst_first", 64'h55, 1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), {$urandom, $urandom},
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
